axis_dot_driver: RTL and testbench
==================================

# axis_dot_driver

On-chip AXI4-Stream initiator that exercises `axis_dot_80_40` from the other end of its streams. Software or a controller loads an input vector of IEEE-754 single-precision words into a local buffer. A `start` pulse sends the vector on a master stream into the dot core's input. The block then collects the result words from the core's output into a readable result buffer and reports the elapsed cycle count. It provides the in-fabric, self-timed equivalent of the bench stimulus/monitor pair and sits between a register-bank front end and the dot core.

## Interface
- `IN_WORDS`, 80: words per input vector; TLAST is driven on the final word.
- `OUT_WORDS`, 40: result words expected per run.
- `TIMEOUT`, 44100: cycle limit per run before the run is aborted.
- `aclk` in 1: sole clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `wr_en` in 1: input-buffer write strobe.
- `wr_addr` in $clog2(IN_WORDS): input-buffer word index.
- `wr_data` in 32: input word.
- `start` in 1: single-cycle run request.
- `busy` out 1: run in progress.
- `done` out 1: run complete, sticky until the next accepted `start`.
- `timeout` out 1: the run ended by timeout, sticky like `done`.
- `err_tlast` out 1: RX TLAST mismatch seen during the run, sticky like `done`.
- `cycles` out 32: cycle count of the last or current run.
- `rd_addr` in $clog2(OUT_WORDS): result-buffer index.
- `rd_data` out 32: result word, registered, 1-cycle latency.
- `M_AXIS_TDATA` out 32, `M_AXIS_TLAST` out 1, `M_AXIS_TVALID` out 1, `M_AXIS_TREADY` in 1: stream to the dot core input.
- `S_AXIS_TDATA` in 32, `S_AXIS_TLAST` in 1, `S_AXIS_TVALID` in 1, `S_AXIS_TREADY` out 1: stream from the dot core output.

## Operation
- FSM has three states:
  - IDLE: the power-on state.
  - RUN: entered on `start`=1 from IDLE or DONE. Entry clears `tx_idx`, `rx_idx`, `cycles`, `done`, `timeout` and `err_tlast`.
  - DONE: entered from RUN on the RX handshake with `rx_idx`=OUT_WORDS-1, or when `cycles` reaches TIMEOUT (this also sets `timeout`=1).
- In RUN, TX and RX are independent and may overlap.
- TX side:
  - `M_AXIS_TVALID`=1 while `tx_idx` < IN_WORDS.
  - `M_AXIS_TDATA` = buf_in[`tx_idx`].
  - `M_AXIS_TLAST` = (`tx_idx`==IN_WORDS-1).
  - `tx_idx` increments on each TVALID&TREADY handshake.
- RX side:
  - `S_AXIS_TREADY`=1 while `rx_idx` < OUT_WORDS.
  - On each handshake, buf_out[`rx_idx`] is written with TDATA and `rx_idx` increments.
  - If TLAST differs from (`rx_idx`==OUT_WORDS-1), `err_tlast` is set. The word is still stored and counting continues.
- `busy`=1 only in RUN.
- `cycles` increments every cycle in RUN, saturates at TIMEOUT, and holds its value in DONE and IDLE.
- Input-buffer writes:
  - Accepted in IDLE and DONE only; `wr_en` is ignored during RUN.
  - `wr_addr` ≥ IN_WORDS is ignored.
- `start` during RUN is ignored.
- Reads:
  - `rd_addr` is valid in any state and returns the current buf_out contents.
  - `rd_addr` ≥ OUT_WORDS returns 0.
- Timeout is an abort. TVALID and TREADY drop even if a beat is unfinished, and the dot core needs a reset before reuse. This is the only permitted AXIS protocol violation.

## Timing
- Values forced by `rst`:
  - State goes to IDLE.
  - `busy`, `done`, `timeout`, `err_tlast`, `cycles`, `rd_data`, `M_AXIS_TVALID`, `M_AXIS_TLAST` and `S_AXIS_TREADY` = 0.
  - `M_AXIS_TDATA` is don't-care.
  - The index counters clear.
  - buf_in and buf_out are not reset; their contents persist across `rst`.
- Reset mid-run: outputs go to the reset values asynchronously and the run is lost; the next `start` restarts from word 0.
- `start` sampled at edge N puts the FSM in RUN after edge N.
  - TVALID is high with word 0 in cycle N+1.
  - With TREADY held at 1, word k is transferred in cycle N+1+k, at one word per cycle.
- Stall: while TVALID=1 and TREADY=0, TDATA and TLAST hold their values.
- `done` rises in the cycle after the final RX handshake. In that same cycle `S_AXIS_TREADY` falls and `busy` falls.
- A simultaneous TX and RX handshake in one cycle advances both counters.
- A `start` coinciding with the final RX handshake is ignored, since the FSM is still in RUN.
- `cycles` equals the number of clock edges spent in RUN.

## Test plan
- Back-to-back: load buf_in[i]=0x3F800000 (1.0) for all i, start, hold TREADY=1.
  - Required: 80 consecutive TX beats, TLAST only on beat 79.
  - A model then returns 40 words 0x42200000..; required `done`=1, `err_tlast`=0, `rd_data` matches at addresses 0..39.
- Backpressure: `M_AXIS_TREADY` toggles every cycle.
  - Required: 80 beats in 160 cycles; TDATA/TLAST stable across every stalled cycle; beat order 0..79.
- RX checks:
  - A model with random TVALID gaps and TLAST on word 39 gives `err_tlast`=0.
  - Repeating with TLAST on word 19 gives `err_tlast`=1, with all 40 words still stored and `done`=1.
- Timeout: TIMEOUT=100, model never asserts `S_AXIS_TVALID`.
  - Required: `done`=1, `timeout`=1, `cycles`=100, and TVALID/TREADY=0 in the cycle after.
- Reset mid-run: assert `rst` during TX beat 30.
  - Required: all outputs 0 immediately.
  - After deassert, a new start with no reload re-sends buf_in from word 0 with unchanged data.
- Ignored inputs: `wr_en` and `start` pulsed during RUN.
  - Required: buf_in unchanged, run unaffected, final `cycles` identical to an undisturbed run.

Source files
------------

// File: rtl/axis_dot_driver_if.sv
// One AXI4-Stream link: 32-bit data with last/valid/ready handshake.
interface axis_dot_driver_if;
    logic [31:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_dot_driver.sv
// Stream initiator for the dot core: sends a buffered input vector, captures
// the result words into a readable buffer and times the run.
module axis_dot_driver #(
    parameter int unsigned IN_WORDS  = 80,
    parameter int unsigned OUT_WORDS = 40,
    parameter int unsigned TIMEOUT   = 44100
) (
    input  logic                         aclk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(IN_WORDS)-1:0]  wr_addr,
    input  logic [31:0]                  wr_data,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout,
    output logic                         err_tlast,
    output logic [31:0]                  cycles,
    input  logic [$clog2(OUT_WORDS)-1:0] rd_addr,
    output logic [31:0]                  rd_data,
    axis_dot_driver_if.master            m_axis,
    axis_dot_driver_if.slave             s_axis
);
    localparam int unsigned IA  = $clog2(IN_WORDS);
    localparam int unsigned OA  = $clog2(OUT_WORDS);
    localparam int unsigned TXW = $clog2(IN_WORDS + 1);
    localparam int unsigned RXW = $clog2(OUT_WORDS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [TXW-1:0] tx_idx;
    logic [RXW-1:0] rx_idx;
    logic [31:0]    buf_in  [IN_WORDS];
    logic [31:0]    buf_out [OUT_WORDS];

    logic           tx_hs;
    logic           rx_hs;
    logic           rx_last;
    logic           rx_final;
    logic [TXW-1:0] tx_next;
    logic [31:0]    cycles_inc;

    assign tx_hs      = m_axis.tvalid & m_axis.tready;
    assign rx_hs      = s_axis.tvalid & s_axis.tready;
    assign rx_last    = (rx_idx == RXW'(OUT_WORDS - 1));
    assign rx_final   = rx_hs & rx_last;
    assign tx_next    = tx_idx + TXW'(1);
    assign cycles_inc = cycles + 32'(1);

    // Run control, TX/RX indices and all status outputs.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            tx_idx        <= '0;
            rx_idx        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            err_tlast     <= 1'b0;
            cycles        <= '0;
            m_axis.tdata  <= '0;
            m_axis.tlast  <= 1'b0;
            m_axis.tvalid <= 1'b0;
            s_axis.tready <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        tx_idx        <= '0;
                        rx_idx        <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        timeout       <= 1'b0;
                        err_tlast     <= 1'b0;
                        cycles        <= '0;
                        m_axis.tdata  <= buf_in[IA'(0)];
                        m_axis.tlast  <= (IN_WORDS == 1);
                        m_axis.tvalid <= 1'b1;
                        s_axis.tready <= 1'b1;
                    end
                end
                RUN: begin
                    cycles <= cycles_inc;
                    if (tx_hs) begin
                        tx_idx        <= tx_next;
                        m_axis.tvalid <= (32'(tx_next) < IN_WORDS);
                        m_axis.tlast  <= (32'(tx_next) == IN_WORDS - 1);
                        if (32'(tx_next) < IN_WORDS)
                            m_axis.tdata <= buf_in[IA'(tx_next)];
                    end
                    if (rx_hs) begin
                        rx_idx <= rx_idx + RXW'(1);
                        if (s_axis.tlast != rx_last)
                            err_tlast <= 1'b1;
                    end
                    // Completion wins over a timeout landing on the same edge.
                    if (rx_final || cycles_inc == TIMEOUT) begin
                        state         <= DONE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        timeout       <= ~rx_final;
                        m_axis.tvalid <= 1'b0;
                        s_axis.tready <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Input buffer: writable only while no run is in flight.
    always_ff @(posedge aclk) begin
        if (wr_en && state != RUN && 32'(wr_addr) < IN_WORDS)
            buf_in[wr_addr] <= wr_data;
    end

    // Result capture; rx_idx never exceeds OUT_WORDS-1 while tready is high.
    always_ff @(posedge aclk) begin
        if (rx_hs)
            buf_out[OA'(rx_idx)] <= s_axis.tdata;
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (32'(rd_addr) < OUT_WORDS)
            rd_data <= buf_out[rd_addr];
        else
            rd_data <= '0;
    end
endmodule

// File: tb/tb_axis_dot_driver.sv
// Directed/randomized bench for axis_dot_driver with a transaction-level model
// of the TX vector, RX responder and expected run length.
module tb_axis_dot_driver;
    localparam int unsigned NI = 80;
    localparam int unsigned NO = 40;

    logic        aclk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [6:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic        start_to = 1'b0;
    logic [5:0]  rd_addr = '0;

    logic        busy, done, timeout, err_tlast;
    logic [31:0] cycles, rd_data;
    logic        busy_to, done_to, timeout_to, err_tlast_to;
    logic [31:0] cycles_to, rd_data_to;

    axis_dot_driver_if m_if ();
    axis_dot_driver_if s_if ();
    axis_dot_driver_if m2_if ();
    axis_dot_driver_if s2_if ();

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_in  [NI];
    logic [31:0] rx_words[NO];

    always #5 aclk = ~aclk;

    axis_dot_driver dut (
        .aclk(aclk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .timeout(timeout), .err_tlast(err_tlast),
        .cycles(cycles), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_axis(m_if.master), .s_axis(s_if.slave)
    );

    axis_dot_driver #(.TIMEOUT(100)) dut_to (
        .aclk(aclk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start_to), .busy(busy_to), .done(done_to), .timeout(timeout_to),
        .err_tlast(err_tlast_to), .cycles(cycles_to), .rd_addr(rd_addr), .rd_data(rd_data_to),
        .m_axis(m2_if.master), .s_axis(s2_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic load_all();
        for (int i = 0; i < NI; i++) begin
            wr_en = 1'b1; wr_addr = 7'(i); wr_data = ref_in[i];
            tick();
        end
        // Out-of-range writes must not alias onto real entries.
        wr_addr = 7'd127; wr_data = 32'hBAD0BAD0; tick();
        wr_addr = 7'd80;  tick();
        wr_en = 1'b0;
    endtask

    task automatic readback();
        for (int i = 0; i < NO; i++) begin
            rd_addr = 6'(i); tick();
            check($sformatf("rd_data[%0d]", i), rd_data, rx_words[i]);
        end
        rd_addr = 6'd45; tick();
        check("rd_data_oob", rd_data, 32'h0);
    endtask

    // tx_pat: 0 always ready, 1 toggling (stall first), 2 random.
    task automatic run(input int tx_pat, input bit rx_gaps, input int tlast_pos,
                       input bit disturb, output int n_edges, output int tx_end);
        int tx_beats = 0, rx_beats = 0, edges = 0;
        bit stalled = 0, tv_checked = 0, tx_hs, rx_hs;
        logic [31:0] held_d = '0;
        logic held_l = 1'b0;
        tx_end = -1;
        start = 1'b1; tick(); start = 1'b0;
        check("busy_at_start", busy, 1'b1);
        check("done_cleared", done, 1'b0);
        check("tvalid_first", m_if.tvalid, 1'b1);
        check("tdata_first", m_if.tdata, ref_in[0]);
        while (rx_beats < NO && edges < 3000) begin
            if (stalled) begin
                check("stall_tdata", m_if.tdata, held_d);
                check("stall_tlast", m_if.tlast, held_l);
            end
            if (tx_beats == NI && !tv_checked) begin
                check("tvalid_after_tx", m_if.tvalid, 1'b0);
                tv_checked = 1;
            end
            case (tx_pat)
                0: m_if.tready = 1'b1;
                1: m_if.tready = edges[0];
                default: m_if.tready = ($urandom_range(0, 1) == 1);
            endcase
            if (tx_beats == NI && (!rx_gaps || $urandom_range(0, 2) != 0)) begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = rx_words[rx_beats];
                s_if.tlast  = (rx_beats == tlast_pos);
            end else begin
                s_if.tvalid = 1'b0;
                s_if.tlast  = 1'b0;
            end
            if (disturb && edges == 10) begin
                wr_en = 1'b1; wr_addr = 7'd5; wr_data = 32'hDEADBEEF; start = 1'b1;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            tx_hs = m_if.tvalid && m_if.tready;
            rx_hs = s_if.tvalid && s_if.tready;
            if (tx_hs) begin
                check($sformatf("tx_data[%0d]", tx_beats), m_if.tdata, ref_in[tx_beats]);
                check($sformatf("tx_last[%0d]", tx_beats), m_if.tlast, 32'(tx_beats == NI - 1));
                tx_beats++;
            end
            stalled = m_if.tvalid && !m_if.tready;
            held_d = m_if.tdata;
            held_l = m_if.tlast;
            tick();
            edges++;
            if (tx_hs && tx_beats == NI) tx_end = edges;
            if (rx_hs) rx_beats++;
        end
        m_if.tready = 1'b0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
        wr_en = 1'b0; start = 1'b0;
        check("run_completed", 32'(rx_beats), 32'(NO));
        check("tx_beats_total", 32'(tx_beats), 32'(NI));
        check("done_end", done, 1'b1);
        check("busy_end", busy, 1'b0);
        check("tready_end", s_if.tready, 1'b0);
        check("timeout_end", timeout, 1'b0);
        check("err_tlast_end", err_tlast, 32'(tlast_pos != NO - 1));
        check("cycles_end", cycles, 32'(edges));
        n_edges = edges;
    endtask

    initial begin
        int n, txe;
        m_if.tready = 1'b0; s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
        m2_if.tready = 1'b0; s2_if.tvalid = 1'b0; s2_if.tdata = '0; s2_if.tlast = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cycles", cycles, 32'h0);
        check("rst_tvalid", m_if.tvalid, 1'b0);
        check("rst_tready", s_if.tready, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);

        // Back-to-back: 80 TX beats, then 40 RX beats, 120 edges in RUN.
        for (int i = 0; i < NI; i++) ref_in[i] = 32'h3F800000;
        for (int i = 0; i < NO; i++) rx_words[i] = 32'h42200000 + 32'(i);
        load_all();
        run(0, 0, NO - 1, 0, n, txe);
        check("b2b_cycles", 32'(n), 32'd120);
        check("b2b_tx_end", 32'(txe), 32'd80);
        readback();

        // Backpressure: toggling ready, 80 beats take 160 cycles.
        for (int i = 0; i < NI; i++) ref_in[i] = $urandom;
        for (int i = 0; i < NO; i++) rx_words[i] = $urandom;
        load_all();
        run(1, 0, NO - 1, 0, n, txe);
        check("bp_tx_end", 32'(txe), 32'd160);
        readback();

        // RX with random gaps, correct TLAST.
        for (int i = 0; i < NO; i++) rx_words[i] = $urandom;
        run(2, 1, NO - 1, 0, n, txe);
        readback();

        // RX with TLAST on word 19: flagged, all words still stored.
        for (int i = 0; i < NO; i++) rx_words[i] = $urandom;
        run(2, 1, 19, 0, n, txe);
        readback();

        // wr_en/start during RUN are ignored; run length matches undisturbed.
        run(0, 0, NO - 1, 1, n, txe);
        check("dist_cycles", 32'(n), 32'd120);

        // Reset during TX beat 30, then rerun without reload.
        start = 1'b1; tick(); start = 1'b0;
        m_if.tready = 1'b1;
        repeat (30) tick();
        check("pre_rst_tdata", m_if.tdata, ref_in[30]);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_timeout", timeout, 1'b0);
        check("mid_rst_err", err_tlast, 1'b0);
        check("mid_rst_cycles", cycles, 32'h0);
        check("mid_rst_rd_data", rd_data, 32'h0);
        check("mid_rst_tvalid", m_if.tvalid, 1'b0);
        check("mid_rst_tlast", m_if.tlast, 1'b0);
        check("mid_rst_tready", s_if.tready, 1'b0);
        m_if.tready = 1'b0;
        tick(); rst = 1'b0; tick();
        for (int i = 0; i < NO; i++) rx_words[i] = $urandom;
        run(0, 0, NO - 1, 0, n, txe);
        check("rerun_cycles", 32'(n), 32'd120);
        readback();

        // Timeout instance: core never answers and never accepts.
        start_to = 1'b1; tick(); start_to = 1'b0;
        check("to_busy", busy_to, 1'b1);
        n = 0;
        while (!done_to && n < 300) begin
            check("to_not_early", timeout_to, 1'b0);
            tick();
            n++;
        end
        check("to_edges", 32'(n), 32'd100);
        check("to_done", done_to, 1'b1);
        check("to_timeout", timeout_to, 1'b1);
        check("to_cycles", cycles_to, 32'd100);
        check("to_tvalid", m2_if.tvalid, 1'b0);
        check("to_tready", s2_if.tready, 1'b0);
        check("to_err", err_tlast_to, 1'b0);
        repeat (3) tick();
        check("to_cycles_hold", cycles_to, 32'd100);
        check("to_done_sticky", done_to, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
